// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end: converts one CPU data request into one or two
// word-granular four-phase accesses on a memory accessor port and returns one response.
module load_store_unit #(
  parameter int SIZE = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              request_valid,
  output logic              request_ready,
  input  logic              request_operation,
  input  logic [SIZE-1:0]   request_address,
  input  logic [1:0]        request_width,
  input  logic              request_signed,
  input  logic [SIZE-1:0]   request_data,
  output logic              response_valid,
  output logic [SIZE-1:0]   response_data,
  output logic              memory_enable,
  output logic              memory_operation,
  input  logic              memory_ready,
  output logic [3:0]        memory_byte_mask,
  output logic [SIZE-3:0]   memory_word_address,
  input  logic [SIZE-1:0]   memory_data_in,
  output logic [SIZE-1:0]   memory_data_out
);
  localparam int WA = SIZE - 2;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FIRST      = 3'd1;
  localparam logic [2:0] S_FIRST_REL  = 3'd2;
  localparam logic [2:0] S_SECOND     = 3'd3;
  localparam logic [2:0] S_SECOND_REL = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              op_q, op_d;
  logic              signed_q, signed_d;
  logic [1:0]        offset_q, offset_d;
  logic [1:0]        width_q, width_d;
  logic [WA-1:0]     word_q, word_d;
  logic [7:0]        mask8_q, mask8_d;
  logic [2*SIZE-1:0] data64_q, data64_d;
  logic [SIZE-1:0]   low_q, low_d;
  logic [SIZE-1:0]   high_q, high_d;

  logic [3:0]        base_mask;
  logic [SIZE-1:0]   req_trunc;
  logic [SIZE-1:0]   read_shift;
  logic [SIZE-1:0]   read_result;
  logic              split;
  logic              in_first, in_second;

  // Width code 3 behaves as a word; write data above the width is discarded here.
  always_comb begin
    base_mask = 4'b1111;
    req_trunc = request_data;
    case (request_width)
      2'd0: begin
        base_mask = 4'b0001;
        req_trunc = {{(SIZE-8){1'b0}}, request_data[7:0]};
      end
      2'd1: begin
        base_mask = 4'b0011;
        req_trunc = {{(SIZE-16){1'b0}}, request_data[15:0]};
      end
      default: ;
    endcase
  end

  assign split = |mask8_q[7:4];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    signed_d = signed_q;
    offset_d = offset_q;
    width_d  = width_q;
    word_d   = word_q;
    mask8_d  = mask8_q;
    data64_d = data64_q;
    low_d    = low_q;
    high_d   = high_q;
    case (state_q)
      S_IDLE: begin
        if (request_valid) begin
          op_d     = request_operation;
          signed_d = request_signed;
          offset_d = request_address[1:0];
          width_d  = (request_width == 2'd3) ? 2'd2 : request_width;
          word_d   = request_address[SIZE-1:2];
          mask8_d  = {4'b0000, base_mask} << request_address[1:0];
          data64_d = {{SIZE{1'b0}}, req_trunc} << {request_address[1:0], 3'b000};
          high_d   = '0;
          state_d  = S_FIRST;
        end
      end
      S_FIRST: begin
        if (memory_ready) begin
          low_d   = memory_data_in;
          state_d = S_FIRST_REL;
        end
      end
      S_FIRST_REL: begin
        if (!memory_ready) state_d = split ? S_SECOND : S_DONE;
      end
      S_SECOND: begin
        if (memory_ready) begin
          high_d  = memory_data_in;
          state_d = S_SECOND_REL;
        end
      end
      S_SECOND_REL: begin
        if (!memory_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      signed_q <= 1'b0;
      offset_q <= '0;
      width_q  <= '0;
      word_q   <= '0;
      mask8_q  <= '0;
      data64_q <= '0;
      low_q    <= '0;
      high_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      signed_q <= signed_d;
      offset_q <= offset_d;
      width_q  <= width_d;
      word_q   <= word_d;
      mask8_q  <= mask8_d;
      data64_q <= data64_d;
      low_q    <= low_d;
      high_q   <= high_d;
    end
  end

  // Handshake outputs depend on the state register alone.
  assign request_ready  = (state_q == S_IDLE);
  assign memory_enable  = (state_q == S_FIRST) || (state_q == S_SECOND);
  assign response_valid = (state_q == S_DONE);

  assign in_first  = (state_q == S_FIRST)  || (state_q == S_FIRST_REL);
  assign in_second = (state_q == S_SECOND) || (state_q == S_SECOND_REL);

  assign memory_operation    = (in_first || in_second) && op_q;
  assign memory_word_address = in_first  ? word_q :
                               in_second ? word_q + WA'(1) : '0;
  assign memory_byte_mask    = in_first  ? mask8_q[3:0] :
                               in_second ? mask8_q[7:4] : 4'b0000;
  assign memory_data_out     = in_first  ? data64_q[SIZE-1:0] :
                               in_second ? data64_q[2*SIZE-1:SIZE] : '0;

  assign read_shift = SIZE'({high_q, low_q} >> {offset_q, 3'b000});

  always_comb begin
    read_result = read_shift;
    case (width_q)
      2'd0: read_result = {{(SIZE-8){signed_q & read_shift[7]}}, read_shift[7:0]};
      2'd1: read_result = {{(SIZE-16){signed_q & read_shift[15]}}, read_shift[15:0]};
      default: ;
    endcase
  end

  assign response_data = (response_valid && !op_q) ? read_result : '0;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end that turns one CPU data request (byte, halfword or word; signed or unsigned; aligned or not) into one or two word-granular accesses on a memory accessor port, which connects to one accessor slot of the memory arbiter. It converts addresses to word address plus byte mask, shifts write data into lane position, and splits accesses that cross a word boundary into two sequential four-phase transactions. It then merges, shifts and extends read data and returns a single response.

## Interface
- SIZE, 32, data/address width in bits; only 32 is supported. Byte lanes = 4, word address width = SIZE-2.
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- request_valid  in  1  request present
- request_ready  out  1  high only in IDLE; a request is accepted when request_valid && request_ready
- request_operation  in  1  0 = read, 1 = write
- request_address  in  SIZE  byte address
- request_width  in  2  0 byte, 1 half, 2 word, 3 treated as word
- request_signed  in  1  sign-extend read result
- request_data  in  SIZE  right-aligned write data; bits above width ignored
- response_valid  out  1  one-cycle completion pulse
- response_data  out  SIZE  read result; 0 for writes
- memory_enable  out  1  accessor request
- memory_operation  out  1  latched request_operation
- memory_ready  in  1  accessor completion
- memory_byte_mask  out  4  lane enables, bit n = bits 8n+7:8n
- memory_word_address  out  SIZE-2  word address
- memory_data_in  in  SIZE  read data from memory
- memory_data_out  out  SIZE  lane-positioned write data

## Operation
- On accept, latch the following:
  - operation, signed flag
  - offset = address[1:0], word = address[SIZE-1:2]
  - bytes = 1/2/4
  - mask8 = ((1<<bytes)-1) << offset
  - data64 = zero-extended request_data << (8*offset)
  - split = |mask8[7:4]
- States: IDLE, FIRST, FIRST_RELEASE, SECOND, SECOND_RELEASE, DONE.
- IDLE: request_ready = 1. On accept, go to FIRST.
- FIRST:
  - memory_enable = 1, word address = word, mask = mask8[3:0], data = data64[31:0].
  - When memory_ready = 1, capture memory_data_in into low_buf and go to FIRST_RELEASE.
- FIRST_RELEASE:
  - memory_enable = 0; address, mask and data stay held.
  - When memory_ready = 0, go to SECOND if split, else DONE.
- SECOND:
  - memory_enable = 1, word address = word+1 (wraps modulo 2^(SIZE-2)), mask = mask8[7:4], data = data64[63:32].
  - When memory_ready = 1, capture into high_buf and go to SECOND_RELEASE.
- SECOND_RELEASE: memory_enable = 0. When memory_ready = 0, go to DONE.
- DONE:
  - response_valid = 1 for this one cycle, then go to IDLE.
  - Read result: r = {high_buf, low_buf} >> (8*offset), truncated to width, then sign- or zero-extended.
  - Write result: response_data = 0.
- memory_operation, byte mask, word address and data out are 0 in IDLE and DONE.
- The unit never issues an access with an all-zero mask; an aligned request always uses exactly one access.

## Timing
- Reset values:
  - state IDLE, so request_ready = 1
  - memory_enable = 0, response_valid = 0, response_data = 0
  - all memory outputs 0
- memory_enable, request_ready and response_valid are decoded from the state register only; there is no combinational path from memory_ready or request_valid.
- Four-phase handshake:
  - Enable stays high until memory_ready is seen high, and drops the next cycle.
  - No new enable is raised until memory_ready has been seen low.
  - Address, mask, data and operation are stable from enable rise until ready falls.
- Latency: response_valid rises the cycle after the final RELEASE state samples memory_ready = 0.
- Accept at cycle T gives memory_enable at T+1.
- request_valid outside IDLE is ignored, with no queueing.
- Reset in any state returns to IDLE next cycle and drops memory_enable. The in-flight access is abandoned and no response is issued.

## Test plan
- Aligned word read at 0x00000100: single access, word 0x40, mask 1111. Memory returns 0xDEADBEEF after 2 cycles -> response_data 0xDEADBEEF, one pulse.
- Byte read at 0x00000102, memory word 0x00800000:
  - signed -> 0xFFFFFF80
  - unsigned -> 0x00000080
- Word write at 0x00000106, data 0x11223344:
  - access 1: word 0x41, mask 1100, data 0x33440000
  - access 2: word 0x42, mask 0011, data 0x00001122
  - response_data 0
- Signed half read at 0xFFFFFFFF:
  - access 1: word 0x3FFFFFFF, mask 1000, returns 0xAB000000
  - access 2: word 0x00000000, mask 0001, returns 0x000000CD
  - response 0xFFFFCDAB
- Memory holds ready high 3 cycles after enable drops on a split request -> second enable rises only after ready is low. request_valid pulsed mid-transaction is ignored, with request_ready = 0 throughout.
- Reset asserted while in SECOND -> next cycle memory_enable = 0, request_ready = 1, response_valid never pulses.
